// File: rtl/vx_commit_arb.sv
// vx_commit_arb: merges the per-slot execute-unit commit streams into one
// writeback stream. Round-robin arbitration that locks onto a source until
// its eop packet. The output side is a 2-entry FIFO (output register plus
// skid entry), and every in_ready is derived only from registered occupancy.
// Optional build macro COMMIT_ARB_PERF_EN adds stall_cycles/block_cycles.
module vx_commit_arb #(
   parameter  int NUM_INPUTS = 5,
   parameter  int DATAW      = 128,
   parameter  int COUNT_W    = 48,
   localparam int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_INPUTS-1:0]       in_valid,
   input  logic [NUM_INPUTS*DATAW-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]       in_eop,
   output logic [NUM_INPUTS-1:0]       in_ready,
   output logic                        out_valid,
   output logic [DATAW-1:0]            out_data,
   output logic                        out_eop,
   output logic [SEL_W-1:0]            out_sel,
   input  logic                        out_ready,
`ifdef COMMIT_ARB_PERF_EN
   output logic [COUNT_W-1:0]          stall_cycles,
   output logic [COUNT_W-1:0]          block_cycles,
`endif
   output logic [COUNT_W-1:0]          commit_count
);

   localparam logic STATE_IDLE   = 1'b0;
   localparam logic STATE_LOCKED = 1'b1;

   // FIFO storage: head is what the output presents, skid absorbs one
   // extra packet accepted while the head is stalled.
   logic [1:0]         occ_q, occ_d;
   logic [DATAW-1:0]   head_data_q, head_data_d;
   logic               head_eop_q, head_eop_d;
   logic [SEL_W-1:0]   head_sel_q, head_sel_d;
   logic [DATAW-1:0]   skid_data_q, skid_data_d;
   logic               skid_eop_q, skid_eop_d;
   logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;

   // Arbitration state
   logic               state_q, state_d;
   logic [SEL_W-1:0]   lock_idx_q, lock_idx_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;

   logic [COUNT_W-1:0] count_q, count_d;

   logic                  skid_full;
   logic [NUM_INPUTS-1:0] gnt;
   logic                  gnt_any;
   logic [SEL_W-1:0]      gnt_idx;
   logic                  push;
   logic                  pop;
   logic [DATAW-1:0]      push_data;
   logic                  push_eop;

   // Full depends only on flops, so ready never sees out_ready combinationally
   assign skid_full = (occ_q == 2'd2);

   // Grant: locked source only, otherwise first valid at or after the pointer
   always_comb begin
      int j;
      j       = 0;
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (state_q == STATE_LOCKED) begin
         gnt_idx = lock_idx_q;
         gnt_any = in_valid[lock_idx_q];
      end else begin
         for (int k = 0; k < NUM_INPUTS; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
            if (!gnt_any && in_valid[j]) begin
               gnt_any = 1'b1;
               gnt_idx = SEL_W'(j);
            end
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   // While reset is held the flops are cleared, but ready must also read 0
   assign in_ready  = gnt & {NUM_INPUTS{~skid_full & reset}};
   assign push      = gnt_any & ~skid_full & reset;
   assign pop       = (occ_q != 2'd0) & out_ready;
   assign push_data = in_data[int'(gnt_idx)*DATAW +: DATAW];
   assign push_eop  = in_eop[gnt_idx];

   // FIFO next state: push fills the head when it is (or becomes) free,
   // otherwise the skid; a pop from full promotes the skid entry.
   always_comb begin
      occ_d       = occ_q;
      head_data_d = head_data_q;
      head_eop_d  = head_eop_q;
      head_sel_d  = head_sel_q;
      skid_data_d = skid_data_q;
      skid_eop_d  = skid_eop_q;
      skid_sel_d  = skid_sel_q;
      case (occ_q)
         2'd0: begin
            if (push) begin
               occ_d       = 2'd1;
               head_data_d = push_data;
               head_eop_d  = push_eop;
               head_sel_d  = gnt_idx;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_data_d = push_data;
               head_eop_d  = push_eop;
               head_sel_d  = gnt_idx;
            end else if (push) begin
               occ_d       = 2'd2;
               skid_data_d = push_data;
               skid_eop_d  = push_eop;
               skid_sel_d  = gnt_idx;
            end else if (pop) begin
               occ_d       = 2'd0;
            end
         end
         2'd2: begin
            // no push possible here: ready is low while full
            if (pop) begin
               occ_d       = 2'd1;
               head_data_d = skid_data_q;
               head_eop_d  = skid_eop_q;
               head_sel_d  = skid_sel_q;
            end
         end
         default: occ_d = 2'd0;
      endcase
   end

   // Lock FSM and round-robin pointer; both move only on accepted packets
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      ptr_d      = ptr_q;
      if (push) begin
         if (push_eop) begin
            state_d = STATE_IDLE;
            if (int'(gnt_idx) == NUM_INPUTS - 1) ptr_d = '0;
            else                                 ptr_d = gnt_idx + SEL_W'(1);
         end else begin
            state_d    = STATE_LOCKED;
            lock_idx_d = gnt_idx;
         end
      end
   end

   // Retired-instruction counter: one per eop packet leaving the block
   always_comb begin
      count_d = count_q;
      if (pop && head_eop_q) count_d = count_q + COUNT_W'(1);
   end

   // State registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q       <= 2'd0;
         head_data_q <= '0;
         head_eop_q  <= 1'b0;
         head_sel_q  <= '0;
         skid_data_q <= '0;
         skid_eop_q  <= 1'b0;
         skid_sel_q  <= '0;
         state_q     <= STATE_IDLE;
         lock_idx_q  <= '0;
         ptr_q       <= '0;
         count_q     <= '0;
      end else begin
         occ_q       <= occ_d;
         head_data_q <= head_data_d;
         head_eop_q  <= head_eop_d;
         head_sel_q  <= head_sel_d;
         skid_data_q <= skid_data_d;
         skid_eop_q  <= skid_eop_d;
         skid_sel_q  <= skid_sel_d;
         state_q     <= state_d;
         lock_idx_q  <= lock_idx_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
      end
   end

   assign out_valid    = (occ_q != 2'd0);
   assign out_data     = head_data_q;
   assign out_eop      = head_eop_q;
   assign out_sel      = head_sel_q;
   assign commit_count = count_q;

`ifdef COMMIT_ARB_PERF_EN
   logic [COUNT_W-1:0] stall_q, stall_d;
   logic [COUNT_W-1:0] block_q, block_d;

   // Stall: output held by writeback; block: someone wants in, nobody got in
   always_comb begin
      stall_d = stall_q;
      block_d = block_q;
      if (out_valid && !out_ready) stall_d = stall_q + COUNT_W'(1);
      if ((|in_valid) && !push)    block_d = block_q + COUNT_W'(1);
   end

   // Perf counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         block_q <= '0;
      end else begin
         stall_q <= stall_d;
         block_q <= block_d;
      end
   end

   assign stall_cycles = stall_q;
   assign block_cycles = block_q;
`endif

endmodule

// File: doc/vx_commit_arb.md
Name: vx_commit_arb

Overview:
- Sits directly downstream of the execute stage, one instance per issue slot.
- Merges the NUM_EX_UNITS commit streams (ALU, LSU, FPU, TCU, SFU) of that slot into the single stream consumed by writeback/scoreboard release.
- Round-robin arbitration with packet lock until eop; registered output with a 2-entry skid buffer so all input ready signals are registered-path clean.

Parameters:
- NUM_INPUTS, 5, number of execution-unit commit streams merged.
- DATAW, 128, commit payload width excluding the eop bit (uuid, wid, tmask, PC, wb, rd, data, pid, sop).
- COUNT_W, 48, width of the committed-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  NUM_INPUTS  per-unit commit valid.
- in_data  in  NUM_INPUTS*DATAW  per-unit payload; unit i at [i*DATAW +: DATAW].
- in_eop  in  NUM_INPUTS  last packet of an instruction's commit.
- in_ready  out  NUM_INPUTS  per-unit accept.
- out_valid  out  1  merged commit valid.
- out_data  out  DATAW  merged payload.
- out_eop  out  1  eop of merged packet.
- out_sel  out  log2(NUM_INPUTS)  source unit index of out_data.
- out_ready  in  1  writeback accept.
- commit_count  out  COUNT_W  instructions retired (eop packets handed off).

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, out_eop=0, out_sel=0, commit_count=0, skid empty, lock clear, RR pointer=0; in_ready=0 while reset is asserted.
- Transfer on a side = valid & ready in the same cycle.
- Arbiter:
  - Combinational grant among in_valid, round-robin starting at pointer.
  - in_ready[i] = grant[i] & ~skid_full.
  - Only one input is accepted per cycle.
- Lock: FSM with IDLE and LOCKED states.
  - IDLE -> LOCKED when a granted transfer has in_eop=0; lock_idx := i.
  - LOCKED: grant forced to lock_idx; other inputs get ready=0 even if lock_idx is not valid.
  - LOCKED -> IDLE on a transfer from lock_idx with eop=1.
  - Pointer := granted index+1 (mod NUM_INPUTS) only on an eop transfer.
- Buffering: 2-entry FIFO (out register + skid), occupancy 0..2.
  - Push on input transfer, pop on output transfer; simultaneous push/pop keeps occupancy.
  - skid_full = (occupancy==2); may be derived from registered state only.
  - out_* presents the FIFO head; out_valid = (occupancy!=0); payload holds stable while out_valid & ~out_ready.
- Latency: 1 cycle from input transfer to out_valid when empty. Throughput: 1 packet/cycle sustained with out_ready=1.
- commit_count increments by 1 on each output transfer with out_eop=1; wraps modulo 2^COUNT_W, no saturation.
- Boundary conditions:
  - Full with no pop: all in_ready=0.
  - Full with pop in the same cycle: still no push (ready derived from registered state).
  - Single requester: granted every cycle regardless of pointer.
  - Reset mid-packet: lock and FIFO are discarded; the unit is expected to be reset too.

Optional Feature:
- Macro COMMIT_ARB_PERF_EN.
- Defined:
  - Adds output stall_cycles (COUNT_W): counts cycles with out_valid & ~out_ready.
  - Adds output block_cycles (COUNT_W): counts cycles with any in_valid & none accepted.
  - Both counters reset to 0 and wrap.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Single unit: in_valid[0]=1, eop=1, data=0xA5, out_ready=1 -> out_valid next cycle, out_data=0xA5, out_sel=0, commit_count=1.
- All 5 units valid, eop=1 each cycle, out_ready=1 -> grant order 0,1,2,3,4,0,…; 5 packets in 5 consecutive cycles; commit_count=5.
- Unit 1 sends 3 packets (eop on 3rd) with a 1-cycle valid gap while unit 2 is valid -> unit 2 ready stays 0 until unit 1's eop; output order 1,1,1,2.
- out_ready=0 for 4 cycles with unit 0 streaming -> exactly 2 packets buffered, in_ready[0]=0 thereafter; after release, the packets drain in order with no loss or duplication.
- Assert reset=0 mid-LOCKED with occupancy 2 -> out_valid=0 immediately (async), commit_count=0; after release, unit 3 is granted first with pointer=0 semantics.
- COMMIT_ARB_PERF_EN: hold out_ready=0 for 10 cycles with a full FIFO -> stall_cycles=10, block_cycles=10.
